// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus responder.
//   state_e    : responder state machine encoding
//   BE_*       : byte-lane enables {upper, lower}
//   ADDR_W/DATA_W : bus word-address and data widths
package m68k_bus_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_WORD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DS,
    REQUEST,
    DTACK,
    RELEASE,
    BERR_HOLD
  } state_e;

endpackage

// File: rtl/bus_sync.sv
// Multi-stage synchroniser for one asynchronous bus strobe.
//   clk, rst : destination clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronised output (resets to RST_VAL)
module bus_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the input in at bit 0; bit STAGES-1 is the settled value.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// Target-side responder for a 68000-style bus master. Synchronises the
// strobes, decodes the address window, runs a REQ/ACK handshake with an
// internal port and terminates the bus cycle with DTACK_n.
//
// Optional feature macro: M68K_RESP_TIMEOUT_EN
//   adds BERR_n and an ACK timeout counter (TIMEOUT cycles in REQUEST).
//
// Ports:
//   CLK, RESET            : clock, async active-high reset
//   AS_n/UDS_n/LDS_n/RnW  : asynchronous bus strobes
//   A, D_IN               : bus address (A[23:1]) and write data
//   D_OUT, D_OE, DTACK_n  : bus read data, output enable, acknowledge
//   REQ, REQ_WR, REQ_ADDR, REQ_BE, REQ_WDATA : internal request
//   ACK, RDATA            : internal completion pulse and read data
//   BERR_n                : bus error (only with M68K_RESP_TIMEOUT_EN)
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 23'h7C0000,
  parameter logic [ADDR_W-1:0]  ADDR_MASK   = 23'h7F0000,
  parameter int unsigned        DTACK_DELAY = 3
`ifdef M68K_RESP_TIMEOUT_EN
  ,
  parameter int unsigned        TIMEOUT     = 255
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AS_n,
  input  logic              UDS_n,
  input  logic              LDS_n,
  input  logic              RnW,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D_IN,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OE,
  output logic              DTACK_n,
  output logic              REQ,
  output logic              REQ_WR,
  output logic [ADDR_W-1:0] REQ_ADDR,
  output logic [1:0]        REQ_BE,
  output logic [DATA_W-1:0] REQ_WDATA,
  input  logic              ACK,
  input  logic [DATA_W-1:0] RDATA
`ifdef M68K_RESP_TIMEOUT_EN
  ,
  output logic              BERR_n
`endif
);

  localparam logic [3:0] DLY_LAST = 4'(DTACK_DELAY - 1);
`ifdef M68K_RESP_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
`endif

  logic s_as_n, s_uds_n, s_lds_n, s_rnw;

  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_as  (.clk(CLK), .rst(RESET), .d(AS_n),  .q(s_as_n));
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_uds (.clk(CLK), .rst(RESET), .d(UDS_n), .q(s_uds_n));
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lds (.clk(CLK), .rst(RESET), .d(LDS_n), .q(s_lds_n));
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rnw (.clk(CLK), .rst(RESET), .d(RnW),   .q(s_rnw));

  state_e              state_q, state_d;
  logic                as_prev_q, as_prev_d;
  logic                req_q, req_d;
  logic                req_wr_q, req_wr_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [1:0]          req_be_q, req_be_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic                d_oe_q, d_oe_d;
  logic                dtack_n_q, dtack_n_d;
  logic [3:0]          dly_q, dly_d;
  logic                ack_seen_q, ack_seen_d;
  logic                abort_q, abort_d;
`ifdef M68K_RESP_TIMEOUT_EN
  logic [7:0]          tmo_q, tmo_d;
  logic                berr_n_q, berr_n_d;
`endif

  logic as_fall;
  logic addr_hit;
  logic acked;

  assign as_fall  = as_prev_q & ~s_as_n;
  assign addr_hit = (A & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  assign acked    = ack_seen_q | ACK;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    as_prev_d   = s_as_n;
    req_d       = req_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    dtack_n_d   = dtack_n_q;
    dly_d       = dly_q;
    ack_seen_d  = ack_seen_q;
    abort_d     = abort_q;
`ifdef M68K_RESP_TIMEOUT_EN
    tmo_d       = tmo_q;
    berr_n_d    = berr_n_q;
`endif

    case (state_q)
      IDLE: begin
        if (as_fall && addr_hit) begin
          req_addr_d = A;
          state_d    = WAIT_DS;
        end
      end

      WAIT_DS: begin
        if (s_as_n) begin
          state_d = IDLE;
        end else if (!s_uds_n || !s_lds_n) begin
          req_be_d    = ~{s_uds_n, s_lds_n};
          req_wr_d    = ~s_rnw;
          req_wdata_d = D_IN;
          req_d       = 1'b1;
          dly_d       = 4'd0;
          ack_seen_d  = 1'b0;
          abort_d     = 1'b0;
`ifdef M68K_RESP_TIMEOUT_EN
          tmo_d       = 8'd0;
`endif
          state_d     = REQUEST;
        end
      end

      REQUEST: begin
        // Delay counter saturates once the minimum DTACK latency is met.
        if (dly_q < DLY_LAST) begin
          dly_d = dly_q + 4'd1;
        end
        abort_d = abort_q | s_as_n;
`ifdef M68K_RESP_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
`endif
        if (!ack_seen_q && ACK) begin
          ack_seen_d = 1'b1;
          req_d      = 1'b0;
          if (!req_wr_q) begin
            d_out_d = RDATA;
          end
        end
        if (acked) begin
          // A master that already left gets no DTACK, only the release cycle.
          if (abort_q || s_as_n) begin
            state_d = RELEASE;
          end else if (dly_q >= DLY_LAST) begin
            dtack_n_d = 1'b0;
            d_oe_d    = ~req_wr_q;
            state_d   = DTACK;
          end
        end
`ifdef M68K_RESP_TIMEOUT_EN
        else if (tmo_q >= TMO_LAST) begin
          req_d    = 1'b0;
          berr_n_d = 1'b0;
          state_d  = BERR_HOLD;
        end
`endif
      end

      DTACK: begin
        if (s_as_n) begin
          dtack_n_d = 1'b1;
          d_oe_d    = 1'b0;
          state_d   = RELEASE;
        end
      end

      RELEASE: begin
        dtack_n_d = 1'b1;
        d_oe_d    = 1'b0;
`ifdef M68K_RESP_TIMEOUT_EN
        berr_n_d  = 1'b1;
`endif
        state_d   = IDLE;
      end

      BERR_HOLD: begin
        if (s_as_n) begin
`ifdef M68K_RESP_TIMEOUT_EN
          berr_n_d = 1'b1;
`endif
          state_d  = RELEASE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      as_prev_q   <= 1'b1;
      req_q       <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= 2'b00;
      req_wdata_q <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      dtack_n_q   <= 1'b1;
      dly_q       <= 4'd0;
      ack_seen_q  <= 1'b0;
      abort_q     <= 1'b0;
`ifdef M68K_RESP_TIMEOUT_EN
      tmo_q       <= 8'd0;
      berr_n_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      as_prev_q   <= as_prev_d;
      req_q       <= req_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      dtack_n_q   <= dtack_n_d;
      dly_q       <= dly_d;
      ack_seen_q  <= ack_seen_d;
      abort_q     <= abort_d;
`ifdef M68K_RESP_TIMEOUT_EN
      tmo_q       <= tmo_d;
      berr_n_q    <= berr_n_d;
`endif
    end
  end

  assign D_OUT     = d_out_q;
  assign D_OE      = d_oe_q;
  assign DTACK_n   = dtack_n_q;
  assign REQ       = req_q;
  assign REQ_WR    = req_wr_q;
  assign REQ_ADDR  = req_addr_q;
  assign REQ_BE    = req_be_q;
  assign REQ_WDATA = req_wdata_q;
`ifdef M68K_RESP_TIMEOUT_EN
  assign BERR_n    = berr_n_q;
`endif

endmodule
